freq_tick_gen: RTL and testbench

//  Parametrised two-stage divider for the clock/display designs. A prescaler
//  on the board clock produces a fast strobe (default 1 kHz, scan rate); a

---
 rtl/freq_tick_gen.sv | 97 +++++++++
 tb/tb_freq_tick_gen.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/freq_tick_gen.sv
// Two-stage strobe divider: prescaler -> fast tick, fast-tick counter -> slow tick.
// Define FREQ_TICK_SQUARE_EN to build the 50%-duty square copies (else they are tied to 0).
module freq_tick_gen #(
  parameter int CLK_HZ  = 100_000_000,
  parameter int FAST_HZ = 1_000,
  parameter int SLOW_HZ = 1,
  localparam int DIV_FAST = CLK_HZ / FAST_HZ,
  localparam int DIV_SLOW = FAST_HZ / SLOW_HZ,
  localparam int FW = (DIV_FAST > 2) ? $clog2(DIV_FAST) : 1,
  localparam int SW = (DIV_SLOW > 2) ? $clog2(DIV_SLOW) : 1
) (
  input  logic          clk_100Mhz,
  input  logic          rst,
  input  logic          en,
  input  logic          clear,
  output logic          tick_1khz,
  output logic          tick_1hz,
  output logic          clk_1khz,
  output logic          clk_1hz,
  output logic [SW-1:0] fast_idx
);

  localparam logic [FW-1:0] PRE_MAX = FW'(DIV_FAST - 1);
  localparam logic [SW-1:0] SEC_MAX = SW'(DIV_SLOW - 1);

  if ((CLK_HZ % FAST_HZ) != 0 || DIV_FAST < 2) begin : g_bad_fast
    $error("freq_tick_gen: CLK_HZ/FAST_HZ must be an exact integer >= 2");
  end
  if ((FAST_HZ % SLOW_HZ) != 0 || DIV_SLOW < 2) begin : g_bad_slow
    $error("freq_tick_gen: FAST_HZ/SLOW_HZ must be an exact integer >= 2");
  end

  logic [FW-1:0] pre_cnt;
  logic [SW-1:0] sec_cnt;
  logic          pre_wrap, sec_last;

  assign pre_wrap = (pre_cnt == PRE_MAX);
  assign sec_last = (sec_cnt == SEC_MAX);
  assign fast_idx = sec_cnt;

  // clear outranks en, so a clear landing on the wrap cycle suppresses that strobe
  always_ff @(posedge clk_100Mhz or posedge rst) begin
    if (rst) begin
      pre_cnt   <= '0;
      sec_cnt   <= '0;
      tick_1khz <= 1'b0;
      tick_1hz  <= 1'b0;
    end else if (clear) begin
      pre_cnt   <= '0;
      sec_cnt   <= '0;
      tick_1khz <= 1'b0;
      tick_1hz  <= 1'b0;
    end else if (en) begin
      pre_cnt   <= pre_wrap ? '0 : pre_cnt + FW'(1);
      if (pre_wrap)
        sec_cnt <= sec_last ? '0 : sec_cnt + SW'(1);
      tick_1khz <= pre_wrap;
      tick_1hz  <= pre_wrap && sec_last;
    end else begin
      tick_1khz <= 1'b0;
      tick_1hz  <= 1'b0;
    end
  end

`ifdef FREQ_TICK_SQUARE_EN
  localparam logic [FW-1:0] PRE_HALF = FW'(DIV_FAST / 2 - 1);
  localparam logic [SW-1:0] SEC_HALF = SW'(DIV_SLOW / 2 - 1);

  if ((DIV_FAST % 2) != 0 || (DIV_SLOW % 2) != 0) begin : g_bad_even
    $error("freq_tick_gen: square outputs need even DIV_FAST and DIV_SLOW");
  end

  // Squares rise with their tick and fall half a period later
  always_ff @(posedge clk_100Mhz or posedge rst) begin
    if (rst) begin
      clk_1khz <= 1'b0;
      clk_1hz  <= 1'b0;
    end else if (clear) begin
      clk_1khz <= 1'b0;
      clk_1hz  <= 1'b0;
    end else if (en) begin
      if (pre_wrap)
        clk_1khz <= 1'b1;
      else if (pre_cnt == PRE_HALF)
        clk_1khz <= 1'b0;
      if (pre_wrap && sec_last)
        clk_1hz <= 1'b1;
      else if (pre_wrap && sec_cnt == SEC_HALF)
        clk_1hz <= 1'b0;
    end
  end
`else
  assign clk_1khz = 1'b0;
  assign clk_1hz  = 1'b0;
`endif

endmodule

// File: tb/tb_freq_tick_gen.sv
// Scoreboard bench for freq_tick_gen at DIV_FAST=10, DIV_SLOW=10.
module tb_freq_tick_gen;

  typedef struct packed {
    logic       t1k;
    logic       t1hz;
    logic       c1k;
    logic       c1hz;
    logic [3:0] idx;
  } out_t;

  logic       clk_100Mhz = 1'b0;
  logic       rst = 1'b1, en = 1'b0, clear = 1'b0;
  logic       tick_1khz, tick_1hz, clk_1khz, clk_1hz;
  logic [3:0] fast_idx;

  freq_tick_gen #(.CLK_HZ(1000), .FAST_HZ(100), .SLOW_HZ(10)) dut (
    .clk_100Mhz(clk_100Mhz), .rst(rst), .en(en), .clear(clear),
    .tick_1khz(tick_1khz), .tick_1hz(tick_1hz),
    .clk_1khz(clk_1khz), .clk_1hz(clk_1hz), .fast_idx(fast_idx)
  );

  always #5 clk_100Mhz = ~clk_100Mhz;

  int   tests = 0, fails = 0;
  int   ph = 0;          // enabled cycles since last reset/clear
  out_t expq[$];

  // Expected outputs after an edge: ph enabled cycles elapsed, live = that edge counted
  function automatic out_t model(input int p, input logic live);
    out_t o;
    o.t1k  = live && (p % 10 == 0) && p > 0;
    o.t1hz = live && (p % 100 == 0) && p > 0;
    o.idx  = 4'((p / 10) % 10);
`ifdef FREQ_TICK_SQUARE_EN
    o.c1k  = (p >= 10) && (p % 10 < 5);
    o.c1hz = (p >= 100) && (p % 100 < 50);
`else
    o.c1k  = 1'b0;
    o.c1hz = 1'b0;
`endif
    return o;
  endfunction

  function automatic out_t observe();
    return {tick_1khz, tick_1hz, clk_1khz, clk_1hz, fast_idx};
  endfunction

  // Drive one cycle, push its expectation, advance past the edge
  task automatic step(input logic e, input logic c);
    logic live;
    en = e;
    clear = c;
    live = 1'b0;
    if (c) ph = 0;
    else if (e) begin ph++; live = 1'b1; end
    expq.push_back(model(ph, live));
    @(posedge clk_100Mhz);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; en = 1'b0; clear = 1'b0; ph = 0;
    @(posedge clk_100Mhz);
    #1;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    out_t o;
    #2;
    o = observe();
    tests++;
    if (o !== '0) begin
      fails++;
      $display("FAIL reset_state got=%h exp=0", o);
    end
    do_reset();
    o = observe();
    tests++;
    if (o !== '0) begin
      fails++;
      $display("FAIL reset_hold got=%h exp=0", o);
    end
  endtask

  task automatic test_run();
    out_t e, o;
    int n1hz = 0;
    do_reset();
    for (int i = 1; i <= 205; i++) begin
      step(1'b1, 1'b0);
      e = expq.pop_front();
      o = observe();
      if (tick_1hz === 1'b1) n1hz++;
      tests++;
      if (o !== e) begin
        fails++;
        $display("FAIL run cyc=%0d got=%h exp=%h", i, o, e);
      end
    end
    tests++;
    if (n1hz !== 2) begin
      fails++;
      $display("FAIL run_1hz_count got=%0d exp=2", n1hz);
    end
  endtask

  task automatic test_pause();
    out_t e, o;
    int gap = -1;
    do_reset();
    for (int i = 1; i <= 30; i++) begin
      if (i >= 5 && i <= 11) step(1'b0, 1'b0);
      else step(1'b1, 1'b0);
      e = expq.pop_front();
      o = observe();
      if (gap < 0 && tick_1khz === 1'b1) gap = i - 11;
      tests++;
      if (o !== e) begin
        fails++;
        $display("FAIL pause cyc=%0d got=%h exp=%h", i, o, e);
      end
    end
    tests++;
    if (gap !== 6) begin
      fails++;
      $display("FAIL pause_resume_gap got=%0d exp=6", gap);
    end
  endtask

  task automatic test_clear();
    out_t e, o;
    do_reset();
    for (int i = 1; i <= 65; i++) begin
      step(1'b1, i == 50);
      e = expq.pop_front();
      o = observe();
      tests++;
      if (o !== e) begin
        fails++;
        $display("FAIL clear cyc=%0d got=%h exp=%h", i, o, e);
      end
    end
  endtask

  task automatic test_async_reset();
    out_t e, o;
    do_reset();
    for (int i = 1; i <= 37; i++) begin
      step(1'b1, 1'b0);
      e = expq.pop_front();
      o = observe();
      tests++;
      if (o !== e) begin
        fails++;
        $display("FAIL pre_areset cyc=%0d got=%h exp=%h", i, o, e);
      end
    end
    #3 rst = 1'b1;
    #1;
    o = observe();
    tests++;
    if (o !== '0 || fast_idx !== 4'd0) begin
      fails++;
      $display("FAIL async_reset got=%h exp=0", o);
    end
    do_reset();
    for (int i = 1; i <= 205; i++) begin
      step(1'b1, 1'b0);
      e = expq.pop_front();
      o = observe();
      tests++;
      if (o !== e) begin
        fails++;
        $display("FAIL post_areset cyc=%0d got=%h exp=%h", i, o, e);
      end
    end
  endtask

  task automatic test_square();
    out_t e, o;
    do_reset();
    for (int i = 1; i <= 1000; i++) begin
      step(1'b1, 1'b0);
      e = expq.pop_front();
      o = observe();
      tests++;
      if (o !== e) begin
        fails++;
        $display("FAIL square cyc=%0d got=%h exp=%h", i, o, e);
      end
    end
    tests++;
    if (expq.size() != 0) begin
      fails++;
      $display("FAIL scoreboard_left got=%0d exp=0", expq.size());
    end
  endtask

  initial begin
    test_reset();
    test_run();
    test_pause();
    test_clear();
    test_async_reset();
    test_square();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
